data_mem_resp: RTL and testbench
================================

// Module: data_mem_resp
// PURPOSE
// - Responder end of the core data-memory interface: behavioural data RAM serving the core's load/store unit.
// - Accepts one request per valid/ready handshake; byte-masked write, or read when mask is 0.
// - Returns exactly one single-cycle rvalid pulse per accepted request (reads and writes alike).
// - Sits between the core's memory port and the top level; used in simulation and FPGA builds.
// PARAMETERS
// - Depth    1024  number of Xlen-bit words; power of two, >= 2
// - Latency  1     cycles from accept edge to rvalid cycle; >= 1
// - Xlen comes from core_pkg (32); mask width Xlen/8.
// PORTS
// - clk_i         in   1       clock; all logic on posedge
// - rst_i         in   1       reset; synchronous, active-high
// - mem_valid_i   in   1       request valid; addr/wdata/wmask stable while high
// - mem_ready_o   out  1       responder can accept; handshake = valid && ready
// - mem_addr_i    in   Xlen    byte address; [1:0] ignored
// - mem_wdata_i   in   Xlen    write data, already lane-aligned by initiator
// - mem_wmask_i   in   Xlen/8  byte-lane write enables; 0 = read
// - mem_rdata_o   out  Xlen    read word, meaningful when mem_rvalid_o
// - mem_rvalid_o  out  1       one-cycle response pulse; no back-pressure
// BEHAVIOUR
// - Reset: state Idle, latency counter 0, mem_rdata_o 0, mem_rvalid_o 0.
//   mem_ready_o gated to 0 in any cycle rst_i is high. RAM contents not reset.
// - Index = mem_addr_i[2 +: $clog2(Depth)]; upper bits ignored, so addresses wrap modulo Depth*4.
// - States and transitions:
//   - Idle: mem_ready_o=1.
//     - On handshake with Latency==1 -> Resp.
//     - On handshake with Latency>1 -> Wait, counter=Latency-1.
//   - Wait: mem_ready_o=0. Counter decrements each cycle; -> Resp when counter==1.
//   - Resp: mem_rvalid_o=1 for exactly this cycle, mem_ready_o=0; -> Idle.
//   - Illegal state -> Idle.
// - Accept edge (valid && ready at posedge):
//   - for each lane i with wmask[i]=1: mem[idx][8i+:8] <= wdata[8i+:8]; other lanes unchanged;
//   - rdata register <= (wmask==0) ? mem[idx] (pre-edge contents) : '0.
// - Timing:
//   - Request accepted at edge t: rvalid high in the cycle after edge t+Latency-1, i.e. Latency cycles after accept.
//   - Minimum spacing between two accepts is Latency+1 cycles.
// - mem_rdata_o is held from the accept edge until the next accept; a write response carries 0.
// - mem_valid_i outside Idle is ignored: no write, no queueing. The initiator keeps valid high until ready.
// - Write-then-read to the same word returns the new data, because writes commit at the accept edge.
// - Reset mid-operation (Wait or Resp): a write already accepted stays committed, the pending response is dropped,
//   and the next cycle is Idle with rvalid 0.
// - Mask values the initiator never produces (e.g. 4'b0110) are still honoured lane-by-lane.
// TESTING
// - Reset: hold rst_i 3 cycles with valid=1 -> ready=0, rvalid=0, rdata=0 throughout; ready=1 first cycle after release.
// - Store then load: write addr 0x10, data 0xDEADBEEF, mask 4'hF; then read 0x10 -> rdata 0xDEADBEEF;
//   the write response has rdata 0.
// - Byte/half merge: after the above, write 0x0000AB00 mask 4'b0010, then 0x12340000 mask 4'b1100;
//   read 0x10 -> 0x1234ABEF.
// - Latency=3: accept at edge t -> rvalid only in cycle t+3, ready low cycles t+1..t+3;
//   valid held in Wait causes no write (verified by later read).
// - Wrap: Depth=1024, write 0x5A5A5A5A to 0x1000 -> read 0x0 returns 0x5A5A5A5A;
//   read 0x13 returns the word at index 4.
// - Reset in Wait (Latency=4): write accepted, rst_i pulsed one cycle later -> no rvalid;
//   subsequent read of that address returns the written data.

Source files
------------

// File: rtl/data_mem_resp.sv
// data_mem_resp: behavioural data RAM on the core memory port; byte-masked writes,
// reads when mask is 0, one rvalid pulse per accepted request after a fixed latency.
module data_mem_resp #(
  parameter int Depth = 1024,
  parameter int Latency = 1,
  localparam int Xlen = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_valid_i,
  output logic              mem_ready_o,
  input  logic [Xlen-1:0]   mem_addr_i,
  input  logic [Xlen-1:0]   mem_wdata_i,
  input  logic [Xlen/8-1:0] mem_wmask_i,
  output logic [Xlen-1:0]   mem_rdata_o,
  output logic              mem_rvalid_o
);
  localparam int Aw = $clog2(Depth);
  localparam int Cw = $clog2(Latency + 1);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state_q, state_d;
  logic [Cw-1:0] cnt_q, cnt_d;
  logic [Xlen-1:0] mem [Depth];
  logic [Aw-1:0] idx;
  logic accept;
  logic unused_addr;
  assign idx = mem_addr_i[2 +: Aw];
  assign unused_addr = ^{mem_addr_i[1:0], mem_addr_i[Xlen-1:2+Aw]};
  assign mem_ready_o = (state_q == S_IDLE) && !rst_i;
  assign mem_rvalid_o = (state_q == S_RESP) && !rst_i;
  assign accept = mem_valid_i && mem_ready_o;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE: begin
        state_d = accept ? ((Latency == 1) ? S_RESP : S_WAIT) : S_IDLE;
        cnt_d = accept ? Cw'(Latency - 1) : cnt_q;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        state_d = (cnt_q == Cw'(1)) ? S_RESP : S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      mem_rdata_o <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (accept) mem_rdata_o <= (mem_wmask_i == '0) ? mem[idx] : '0;
    end
  end
  // RAM contents survive reset; a write commits at its accept edge
  always_ff @(posedge clk_i) begin
    if (accept)
      for (int i = 0; i < Xlen/8; i++)
        if (mem_wmask_i[i]) mem[idx][8*i +: 8] <= mem_wdata_i[8*i +: 8];
  end
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: three responders (latency 1, 3, 4) driven in turn; expected responses
// are queued at handshake time and checked, with their arrival cycle, on each rvalid pulse.
module tb_data_mem_resp;
  typedef struct {
    int          dut;
    logic [31:0] data;
    int          due;
  } exp_t;
  logic clk_i = 0;
  logic rst_i = 1;
  logic [2:0] valid = '0;
  logic [2:0] ready, rvalid;
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic [3:0] wmask [3];
  logic [31:0] rdata [3];
  exp_t sb [$];
  int cyc = 0;
  int errs = 0;
  int checks = 0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_resp #(.Depth(1024), .Latency(g == 0 ? 1 : (g == 1 ? 3 : 4))) dut (
      .clk_i(clk_i), .rst_i(rst_i), .mem_valid_i(valid[g]), .mem_ready_o(ready[g]),
      .mem_addr_i(addr[g]), .mem_wdata_i(wdata[g]), .mem_wmask_i(wmask[g]),
      .mem_rdata_o(rdata[g]), .mem_rvalid_o(rvalid[g])
    );
    always @(negedge clk_i) begin
      if (rvalid[g]) begin
        if (sb.size() == 0 || sb[0].dut != g) begin
          errs++;
          checks++;
          $error("FAIL stray_rvalid dut%0d: got rvalid=1 at cycle %0d required no response", g, cyc);
        end else begin
          chk($sformatf("rdata dut%0d", g), rdata[g], sb[0].data);
          chk($sformatf("rvalid_cycle dut%0d", g), 32'(cyc), 32'(sb[0].due));
          void'(sb.pop_front());
        end
      end
    end
  end
  function automatic int lat(input int d);
    return d == 0 ? 1 : (d == 1 ? 3 : 4);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask
  task automatic req(input int d, input logic [31:0] a, input logic [31:0] w, input logic [3:0] m,
                     input logic [31:0] e, input bit push);
    int n;
    valid[d] = 1;
    addr[d] = a;
    wdata[d] = w;
    wmask[d] = m;
    for (n = 0; n < 20 && !ready[d]; n++) @(negedge clk_i);
    if (!ready[d]) begin
      errs++;
      checks++;
      $error("FAIL ready_timeout dut%0d: got ready=0 for 20 cycles required 1", d);
    end else if (push) sb.push_back('{d, e, cyc + lat(d)});
    @(negedge clk_i);
    valid[d] = 0;
  endtask
  task automatic drain();
    for (int n = 0; n < 20 && sb.size() > 0; n++) @(negedge clk_i);
    if (sb.size() > 0) begin
      errs++;
      checks++;
      $error("FAIL resp_timeout: got %0d responses missing required 0", sb.size());
      sb.delete();
    end
  endtask
  initial begin
    for (int d = 0; d < 3; d++) begin
      valid[d] = 1;
      addr[d] = 32'h10;
      wdata[d] = 32'hFFFF_FFFF;
      wmask[d] = 4'hF;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("rst_ready dut%0d", d), 32'(ready[d]), 32'd0);
        chk($sformatf("rst_rvalid dut%0d", d), 32'(rvalid[d]), 32'd0);
        chk($sformatf("rst_rdata dut%0d", d), rdata[d], 32'd0);
      end
    end
    rst_i = 0;
    valid = '0;
    #1;
    for (int d = 0; d < 3; d++) chk($sformatf("ready_after_rst dut%0d", d), 32'(ready[d]), 32'd1);
    @(negedge clk_i);
    req(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1);
    req(0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1);
    req(0, 32'h10, 32'h0000_AB00, 4'b0010, 32'h0, 1);
    req(0, 32'h10, 32'h1234_0000, 4'b1100, 32'h0, 1);
    req(0, 32'h10, 32'h0, 4'h0, 32'h1234_ABEF, 1);
    req(0, 32'h1000, 32'h5A5A_5A5A, 4'hF, 32'h0, 1);
    req(0, 32'h0, 32'h0, 4'h0, 32'h5A5A_5A5A, 1);
    req(0, 32'h13, 32'h0, 4'h0, 32'h1234_ABEF, 1);
    req(0, 32'h10, 32'hFFFF_FFFF, 4'b0110, 32'h0, 1);
    req(0, 32'h10, 32'h0, 4'h0, 32'h12FF_FFEF, 1);
    drain();
    req(1, 32'h20, 32'h1111_1111, 4'hF, 32'h0, 1);
    drain();
    req(1, 32'h24, 32'h2222_2222, 4'hF, 32'h0, 1);
    valid[1] = 1;
    addr[1] = 32'h20;
    wdata[1] = 32'hBAD0_BAD0;
    wmask[1] = 4'hF;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("busy_ready_lat3 c%0d", k + 1), 32'(ready[1]), 32'd0);
      if (k == 2) valid[1] = 0;
      @(negedge clk_i);
    end
    drain();
    req(1, 32'h20, 32'h0, 4'h0, 32'h1111_1111, 1);
    req(1, 32'h24, 32'h0, 4'h0, 32'h2222_2222, 1);
    drain();
    req(2, 32'h40, 32'hCAFE_F00D, 4'hF, 32'h0, 0);
    rst_i = 1;
    @(negedge clk_i);
    rst_i = 0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("no_rvalid_after_rst c%0d", k), 32'(rvalid[2]), 32'd0);
      @(negedge clk_i);
    end
    req(2, 32'h40, 32'h0, 4'h0, 32'hCAFE_F00D, 1);
    drain();
    repeat (3) @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
